multicycle_ctrl: RTL

//  Moore FSM control unit sequencing the multicycle datapath (PC, IR, RegFile, ALU, DataMem, inter-stage regs).

---
 rtl/multicycle_ctrl_if.sv | 56 +++++
 rtl/multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller (master) receives opcode/zero and drives state plus
// every datapath write-enable and mux select; the datapath is the slave.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       ExtSel;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       DataMemRW;
    logic       ALUM2Reg;
    logic       RegWre;
    logic       WrRegData;
    logic [1:0] RegOut;
    logic [1:0] PCSrc;

    modport master (
        input  opcode,
        input  zero,
        output state,
        output PCWre,
        output IRWre,
        output InsMemRW,
        output ExtSel,
        output ALUSrcB,
        output ALUOp,
        output DataMemRW,
        output ALUM2Reg,
        output RegWre,
        output WrRegData,
        output RegOut,
        output PCSrc
    );

    modport slave (
        output opcode,
        output zero,
        input  state,
        input  PCWre,
        input  IRWre,
        input  InsMemRW,
        input  ExtSel,
        input  ALUSrcB,
        input  ALUOp,
        input  DataMemRW,
        input  ALUM2Reg,
        input  RegWre,
        input  WrRegData,
        input  RegOut,
        input  PCSrc
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control unit for the multicycle CPU datapath.
// Sequences each instruction through IF/ID/EXE/MEM/WB and decodes every
// write-enable and mux select from the registered state and the IR opcode.
//
// state  | code | meaning
// -------+------+-------------------------------------------------------
// IF     | 000  | fetch: IR <= mem[PC]
// ID     | 001  | decode; jumps and undefined opcodes retire here; halt parks here
// EXE_A  | 110  | ALU op for R-type / immediate arithmetic
// EXE_B  | 101  | beq compare, branch retires here
// EXE_C  | 010  | address calculation for lw/sw
// MEM    | 011  | data memory access; sw retires here
// WB_A   | 111  | ALU result writeback
// WB_C   | 100  | load data writeback
module multicycle_ctrl #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic              CLK,
    input  logic              RST,
    multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] REG_31 = 2'b00;
    localparam logic [1:0] REG_RT = 2'b01;
    localparam logic [1:0] REG_RD = 2'b10;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_A = 3'b110,
        S_EXE_B = 3'b101,
        S_EXE_C = 3'b010,
        S_MEM   = 3'b011,
        S_WB_A  = 3'b111,
        S_WB_C  = 3'b100
    } state_t;

    state_t state_q;
    state_t state_d;

    logic is_rtype;
    logic is_sub;
    logic is_or;
    logic is_and;
    logic is_slt;
    logic is_addi;
    logic is_ori;
    logic is_sw;
    logic is_lw;
    logic is_beq;
    logic is_j;
    logic is_jr;
    logic is_jal;
    logic is_halt;
    logic is_undef;

    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       ext_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       data_mem_rw;
    logic       alu_m2reg;
    logic       reg_wre;
    logic       wr_reg_data;
    logic [1:0] reg_out;
    logic [1:0] pc_src;

    // State register; reset aborts any in-flight instruction back to fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode classification; halt is checked first so HALT_OP always wins.
    always_comb begin
        is_rtype = 1'b0;
        is_sub   = 1'b0;
        is_or    = 1'b0;
        is_and   = 1'b0;
        is_slt   = 1'b0;
        is_addi  = 1'b0;
        is_ori   = 1'b0;
        is_sw    = 1'b0;
        is_lw    = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        is_jal   = 1'b0;
        is_halt  = 1'b0;
        is_undef = 1'b0;
        if (bus.opcode == HALT_OP) begin
            is_halt = 1'b1;
        end else begin
            case (bus.opcode)
                OP_ADD:  is_rtype = 1'b1;
                OP_SUB:  begin is_rtype = 1'b1; is_sub = 1'b1; end
                OP_OR:   begin is_rtype = 1'b1; is_or  = 1'b1; end
                OP_AND:  begin is_rtype = 1'b1; is_and = 1'b1; end
                OP_SLT:  begin is_rtype = 1'b1; is_slt = 1'b1; end
                OP_ADDI: is_addi = 1'b1;
                OP_ORI:  is_ori  = 1'b1;
                OP_SW:   is_sw   = 1'b1;
                OP_LW:   is_lw   = 1'b1;
                OP_BEQ:  is_beq  = 1'b1;
                OP_J:    is_j    = 1'b1;
                OP_JR:   is_jr   = 1'b1;
                OP_JAL:  is_jal  = 1'b1;
                default: is_undef = 1'b1;
            endcase
        end
    end

    // Next-state: route out of ID by instruction class, then fixed chains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_halt) begin
                    state_d = S_ID;
                end else if (is_beq) begin
                    state_d = S_EXE_B;
                end else if (is_sw || is_lw) begin
                    state_d = S_EXE_C;
                end else if (is_rtype || is_addi || is_ori) begin
                    state_d = S_EXE_A;
                end else begin
                    // j/jr/jal and undefined opcodes all retire in ID
                    state_d = S_IF;
                end
            end
            S_EXE_A: state_d = S_WB_A;
            S_WB_A:  state_d = S_IF;
            S_EXE_B: state_d = S_IF;
            S_EXE_C: state_d = S_MEM;
            S_MEM:   state_d = is_lw ? S_WB_C : S_IF;
            S_WB_C:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Output decode: enables from state, selects from opcode (held at 0 in IF).
    always_comb begin
        pc_wre      = 1'b0;
        ir_wre      = 1'b0;
        ins_mem_rw  = 1'b1;
        ext_sel     = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = ALU_ADD;
        data_mem_rw = 1'b0;
        alu_m2reg   = 1'b0;
        reg_wre     = 1'b0;
        wr_reg_data = 1'b0;
        reg_out     = REG_31;
        pc_src      = PC_NEXT;

        if (state_q == S_IF) begin
            ir_wre = 1'b1;
        end else begin
            ext_sel     = ~is_ori;
            alu_src_b   = is_addi | is_ori | is_sw | is_lw;
            wr_reg_data = ~is_jal;

            if (is_sub || is_beq) begin
                alu_op = ALU_SUB;
            end else if (is_or || is_ori) begin
                alu_op = ALU_OR;
            end else if (is_and) begin
                alu_op = ALU_AND;
            end else if (is_slt) begin
                alu_op = ALU_SLT;
            end

            if (is_addi || is_ori || is_lw) begin
                reg_out = REG_RT;
            end else if (is_rtype) begin
                reg_out = REG_RD;
            end

            if (is_j || is_jal) begin
                pc_src = PC_JUMP;
            end else if (is_jr) begin
                pc_src = PC_RS;
            end else if (is_beq && state_q == S_EXE_B && bus.zero) begin
                pc_src = PC_BRANCH;
            end
        end

        // One PC update per retired instruction, in its final state
        case (state_q)
            S_ID:    pc_wre = is_j | is_jr | is_jal | is_undef;
            S_EXE_B: pc_wre = 1'b1;
            S_MEM:   pc_wre = is_sw;
            S_WB_A:  pc_wre = 1'b1;
            S_WB_C:  pc_wre = 1'b1;
            default: pc_wre = 1'b0;
        endcase

        reg_wre     = (state_q == S_WB_A) || (state_q == S_WB_C) ||
                      (state_q == S_ID && is_jal);
        data_mem_rw = (state_q == S_MEM) && is_sw;
        alu_m2reg   = (state_q == S_WB_C);
    end

    assign bus.state     = state_q;
    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.InsMemRW  = ins_mem_rw;
    assign bus.ExtSel    = ext_sel;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.DataMemRW = data_mem_rw;
    assign bus.ALUM2Reg  = alu_m2reg;
    assign bus.RegWre    = reg_wre;
    assign bus.WrRegData = wr_reg_data;
    assign bus.RegOut    = reg_out;
    assign bus.PCSrc     = pc_src;

endmodule
